// File: rtl/time_set_ctrl.sv
// time_set_ctrl: set-mode sequencer driving field counter inc/dec pulses; define TIME_SET_AUTO_REPEAT_EN for held-button auto-repeat
module time_set_ctrl #(
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       pulse_1s,
  input  logic       pulse_blink,
  output logic       enable_cnt,
  output logic [5:0] inc_sel,
  output logic [5:0] dec_sel,
  output logic [2:0] field,
  output logic       blink
);
  localparam logic [2:0] RUN      = 3'd0;
  localparam logic [2:0] SET_SEC  = 3'd1;
  localparam logic [2:0] SET_YEAR = 3'd6;
  localparam int TW = $clog2(TIMEOUT_S) + 1;
  logic [2:0] state, nxt, btn_q, btn_d, press;
  logic [TW-1:0] to_cnt;
  logic in_set, up_p, dn_p, to_hit, rep_up, rep_dn, time_out;
  assign field    = state;
  assign press    = btn_q & ~btn_d;
  assign in_set   = state != RUN;
  assign up_p     = in_set & press[1] & ~press[2] & ~press[0];
  assign dn_p     = in_set & press[2] & ~press[1] & ~press[0];
  assign to_hit   = in_set & pulse_1s & ~|press & (to_cnt == TW'(TIMEOUT_S - 1));
  assign time_out = to_hit & ~(rep_up | rep_dn);
  assign nxt      = press[0] ? (state == SET_YEAR ? RUN : state + 3'd1) : time_out ? RUN : state;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int HW = $clog2(HOLD_CYC) + 1;
  logic [HW-1:0] hold_cnt;
  logic hold_run, hold_fire;
  assign hold_run  = in_set & (btn_q[1] ^ btn_q[2]) & ~|press;
  assign hold_fire = hold_run & (hold_cnt == HW'(HOLD_CYC - 1));
  assign rep_up    = hold_fire & btn_q[1];
  assign rep_dn    = hold_fire & btn_q[2];
  // after the first repeat the counter restarts part-way so later repeats come every REPEAT_CYC
  always_ff @(posedge clk)
    hold_cnt <= (rst | ~hold_run | time_out) ? '0 :
                hold_fire ? HW'(HOLD_CYC - REPEAT_CYC) : hold_cnt + 1'b1;
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_CYC, REPEAT_CYC};
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q      <= {btn_down, btn_up, btn_mode};
      btn_d      <= {btn_down, btn_up, btn_mode};
      state      <= RUN;
      enable_cnt <= 1'b1;
      inc_sel    <= '0;
      dec_sel    <= '0;
      to_cnt     <= '0;
      blink      <= 1'b0;
    end else begin
      btn_q      <= {btn_down, btn_up, btn_mode};
      btn_d      <= btn_q;
      state      <= nxt;
      enable_cnt <= nxt == RUN;
      inc_sel    <= (up_p | rep_up) ? 6'd1 << (state - SET_SEC) : '0;
      dec_sel    <= (dn_p | rep_dn) ? 6'd1 << (state - SET_SEC) : '0;
      to_cnt     <= (|press | rep_up | rep_dn | (nxt != state)) ? '0 :
                    (in_set & pulse_1s & (to_cnt != TW'(TIMEOUT_S))) ? to_cnt + 1'b1 : to_cnt;
      blink      <= ((nxt != state) | ~in_set) ? 1'b0 : blink ^ pulse_blink;
    end
  end
endmodule
